// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store front end between the core memory stage and a
//            word-wide, byte-addressable data RAM. Performs RISC-V LB/LH/LW/
//            LBU/LHU loads with lane extraction and sign/zero extension,
//            SW as a single write, and SB/SH as read-modify-write. Illegal
//            funct3 or misaligned accesses are answered with an error.
// Ports    : clock, reset_n (sync, active-low)
//            req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata - core
//            rsp_valid/rsp_rdata/rsp_err                              - core
//            mem_we/mem_addr/mem_d/mem_q                              - RAM
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int MEM_DEPTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 mem_we,
    output logic [MEM_DEPTH-1:0] mem_addr,
    output logic [31:0]          mem_d,
    input  logic [31:0]          mem_q
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOAD   = 3'd1;
    localparam logic [2:0] c_ST_STORE  = 3'd2;
    localparam logic [2:0] c_ST_RMW_RD = 3'd3;
    localparam logic [2:0] c_ST_RMW_WR = 3'd4;
    localparam logic [2:0] c_ST_RESP   = 3'd5;
    localparam logic [2:0] c_ST_ERR    = 3'd6;

    logic [2:0]           r_state;
    logic [2:0]           r_funct3;
    logic [1:0]           r_lane;
    logic [15:0]          r_wdata;
    logic                 r_rsp_valid;
    logic                 r_rsp_err;
    logic [31:0]          r_rsp_rdata;
    logic [MEM_DEPTH-1:0] r_mem_addr;
    logic [31:0]          r_mem_d;

    logic        w_legal;
    logic        w_misalign;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    // Address bits above the RAM size are deliberately ignored (aliasing).
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = &{1'b0, req_addr[31:MEM_DEPTH]};

    assign req_ready = (r_state == c_ST_IDLE) && reset_n;
    // Gating with reset_n keeps the RAM from being written at a reset edge
    // even when reset lands in the middle of a write state.
    assign mem_we    = ((r_state == c_ST_STORE) || (r_state == c_ST_RMW_WR)) && reset_n;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_d     = r_mem_d;

    always_comb begin
        w_legal = 1'b0;
        if (req_we) begin
            w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                      (req_funct3 == 3'b010);
        end else begin
            w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                      (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                      (req_funct3 == 3'b101);
        end
        w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    // Lane extraction for loads, from the word currently on mem_q.
    always_comb begin
        w_byte = mem_q[{r_lane, 3'b000} +: 8];
        w_half = r_lane[1] ? mem_q[31:16] : mem_q[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'h000000, w_byte};
            3'b101:  w_load = {16'h0000, w_half};
            default: w_load = mem_q;
        endcase
    end

    // Sub-word store merge: old word with the addressed lane replaced.
    always_comb begin
        w_merge = mem_q;
        if (r_funct3[1:0] == 2'b00) begin
            w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= c_ST_IDLE;
            r_funct3    <= 3'b000;
            r_lane      <= 2'b00;
            r_wdata     <= 16'h0000;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_mem_addr  <= '0;
            r_mem_d     <= 32'h0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_funct3 <= req_funct3;
                        r_lane   <= req_addr[1:0];
                        r_wdata  <= req_wdata[15:0];
                        if (!w_legal || w_misalign) begin
                            // Response is raised on entry so it shows in the ERR cycle.
                            r_state     <= c_ST_ERR;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'h0;
                        end else begin
                            r_mem_addr <= {req_addr[MEM_DEPTH-1:2], 2'b00};
                            if (!req_we) begin
                                r_state <= c_ST_LOAD;
                            end else if (req_funct3[1:0] == 2'b10) begin
                                r_state <= c_ST_STORE;
                                r_mem_d <= req_wdata;
                            end else begin
                                r_state <= c_ST_RMW_RD;
                            end
                        end
                    end
                end
                c_ST_LOAD: begin
                    r_rsp_rdata <= w_load;
                    r_rsp_valid <= 1'b1;
                    r_state     <= c_ST_RESP;
                end
                c_ST_STORE: begin
                    r_rsp_rdata <= 32'h0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= c_ST_RESP;
                end
                c_ST_RMW_RD: begin
                    // mem_d doubles as the merge register for the write cycle.
                    r_mem_d <= w_merge;
                    r_state <= c_ST_RMW_WR;
                end
                c_ST_RMW_WR: begin
                    r_rsp_rdata <= 32'h0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= c_ST_RESP;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit. A byte-array reference
//            memory predicts every response; expectations are queued by the
//            driver and consumed by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_d;
    logic [31:0] mem_q;

    mem_access_unit #(.MEM_DEPTH(16)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_d      (mem_d),
        .mem_q      (mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM: combinational read, zero while writing, write on posedge.
    logic [31:0] ram [0:16383];
    assign mem_q = mem_we ? 32'h0 : ram[mem_addr[15:2]];
    always @(posedge clock) if (mem_we) ram[mem_addr[15:2]] <= mem_d;

    // Reference memory, byte granular.
    logic [7:0] gmem [0:65535];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
        int          nwe;
        int          we_cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          we_cnt = 0;
    int          we_last = 0;
    logic [31:0] last_rdata = 32'h0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // Reference prediction from the access rules, applied to the byte array.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit commit);
        exp_t        e;
        int          n;
        logic [15:0] a0, a1, a2, a3;
        logic [7:0]  b;
        logic [15:0] h;
        bit          legal, mis;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        n = 0;
        forever begin
            #3;
            if (req_ready) break;
            n++;
            if (n > 20) begin
                chk("accept_timeout", 32'd0, 32'd1);
                req_valid = 1'b0;
                return;
            end
            @(posedge clock); #1;
        end
        a0 = addr[15:0];
        a1 = a0 + 16'd1;
        a2 = a0 + 16'd2;
        a3 = a0 + 16'd3;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis   = (f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] != 2'd0);
        e.acc = cyc;
        e.rdata = 32'h0;
        e.err = 1'b0;
        e.nwe = 0;
        e.we_cyc = 0;
        if (!legal || mis) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (!we) begin
            e.lat = 2;
            b = gmem[a0];
            h = {gmem[a1], gmem[a0]};
            case (f3)
                3'd0: e.rdata = b[7]  ? {24'hFFFFFF, b} : {24'h0, b};
                3'd1: e.rdata = h[15] ? {16'hFFFF, h}   : {16'h0, h};
                3'd4: e.rdata = {24'h0, b};
                3'd5: e.rdata = {16'h0, h};
                default: e.rdata = {gmem[a3], gmem[a2], gmem[a1], gmem[a0]};
            endcase
        end else begin
            e.nwe = 1;
            e.lat    = (f3 == 3'd2) ? 2 : 3;
            e.we_cyc = cyc + e.lat - 1;
            if (commit) begin
                gmem[a0] = wd[7:0];
                if (f3 != 3'd0) gmem[a1] = wd[15:8];
                if (f3 == 3'd2) begin
                    gmem[a2] = wd[23:16];
                    gmem[a3] = wd[31:24];
                end
            end
        end
        q.push_back(e);
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            chk("we_in_reset", {31'h0, mem_we}, 32'h0);
            chk("ready_in_reset", {31'h0, req_ready}, 32'h0);
        end else begin
            chk("addr_align", {30'h0, mem_addr[1:0]}, 32'h0);
            if (!rsp_valid) begin
                chk("err_without_valid", {31'h0, rsp_err}, 32'h0);
                chk("rdata_hold", rsp_rdata, last_rdata);
            end
            if (mem_we) begin
                we_cnt++;
                we_last = cyc;
            end
            if (q.size() > 0 && cyc > q[0].acc)
                chk("ready_while_busy", {31'h0, req_ready}, 32'h0);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    chk("we_count", 32'(we_cnt), 32'(e.nwe));
                    if (e.nwe > 0) chk("we_cycle", 32'(we_last), 32'(e.we_cyc));
                end
                we_cnt = 0;
                last_rdata = rsp_rdata;
            end else if (q.size() > 0 && cyc > q[0].acc + 6) begin
                chk("rsp_timeout", 32'd0, 32'd1);
                void'(q.pop_front());
            end
        end
    end

    task automatic check_reset_values(input logic exp_ready);
        chk("rst_ready", {31'h0, req_ready}, {31'h0, exp_ready});
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
        chk("rst_mem_d", mem_d, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
        for (int i = 0; i < 65536; i++) gmem[i] = 8'h0;
        reset_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_values(1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        check_reset_values(1'b1);
        @(posedge clock); #1;

        // Word store and reload.
        issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1);
        idle(1);
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
        idle(2);
        // Byte store into a known word.
        issue(1'b1, 3'd2, 32'h20, 32'h11223344, 1'b1);
        idle(1);
        issue(1'b1, 3'd0, 32'h22, 32'h000000AA, 1'b1);
        idle(1);
        issue(1'b0, 3'd2, 32'h20, 32'h0, 1'b1);
        idle(1);
        // Extension cases.
        issue(1'b1, 3'd2, 32'h30, 32'h8000807F, 1'b1);
        issue(1'b0, 3'd0, 32'h31, 32'h0, 1'b1);
        issue(1'b0, 3'd4, 32'h31, 32'h0, 1'b1);
        issue(1'b0, 3'd1, 32'h32, 32'h0, 1'b1);
        issue(1'b0, 3'd5, 32'h30, 32'h0, 1'b1);
        idle(1);
        // Errors.
        issue(1'b0, 3'd1, 32'h41, 32'h0, 1'b1);
        issue(1'b0, 3'd2, 32'h42, 32'h0, 1'b1);
        issue(1'b0, 3'd3, 32'h40, 32'h0, 1'b1);
        issue(1'b1, 3'd4, 32'h40, 32'h12345678, 1'b1);
        idle(2);

        // Reset in the write cycle of a halfword RMW: nothing may be written.
        issue(1'b1, 3'd1, 32'h50, 32'h00005555, 1'b0);
        req_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b0;
        q.delete();
        we_cnt = 0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        last_rdata = 32'h0;
        @(negedge clock);
        check_reset_values(1'b1);
        @(posedge clock); #1;
        issue(1'b0, 3'd2, 32'h50, 32'h0, 1'b1);
        idle(2);

        // Valid held high back to back, with aliased addresses.
        issue(1'b0, 3'd2, 32'h0001_0010, 32'h0, 1'b1);
        issue(1'b1, 3'd2, 32'h0001_0010, 32'hCAFEF00D, 1'b1);
        issue(1'b1, 3'd0, 32'h0001_0013, 32'h0000005A, 1'b1);
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
        idle(2);

        // Randomized traffic in a small window so accesses collide.
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                if (we) f3 = 3'($urandom_range(0, 2));
                else begin
                    f3 = 3'($urandom_range(0, 4));
                    if (f3 == 3'd3) f3 = 3'd5;
                end
            end
            addr = 32'($urandom_range(0, 95));
            if ($urandom_range(0, 3) == 0) addr = addr | ($urandom & 32'hFFFF_0000);
            issue(we, f3, addr, $urandom, 1'b1);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
        end
        idle(10);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end that lets the core issue RISC-V byte/halfword/word loads and stores against the word-wide, byte-addressable data RAM. It sits between the core's memory stage and the RAM port. RAM write data is word-only and RAM read data is zero while write enable is high, so the block does sub-word stores as read-modify-write: one read cycle, then one write cycle. It also does sub-word load extraction and sign/zero extension, and rejects misaligned or illegal accesses.

## Interface
- MEM_DEPTH, 16, RAM byte-address width; must equal the RAM's MEM_DEPTH.
- clock  in  1  single clock; all state changes on posedge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle pulse; response is complete.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid; access was rejected.
- mem_we  out  1  to RAM write enable.
- mem_addr  out  MEM_DEPTH  to RAM address; always word-aligned ([1:0] = 0).
- mem_d  out  32  to RAM write data.
- mem_q  in  32  from RAM; combinational read of mem_addr when mem_we = 0.

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP, ERR.
- IDLE: req_ready = 1. On a cycle with req_valid=1 and req_ready=1, latch we, funct3, addr, wdata.
  - Illegal funct3 or misaligned access -> ERR. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - Legal load -> LOAD.
  - SW -> STORE.
  - SB/SH -> RMW_RD.
- Address mapping: mem_addr = {addr[MEM_DEPTH-1:2], 2'b00}. Upper address bits are ignored, so accesses wrap modulo 2^MEM_DEPTH.
- LOAD: mem_we=0. Sample mem_q, then extract the lane:
  - byte lane is addr[1:0]; half lane is addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Register the result into rsp_rdata, then go to RESP.
- STORE: mem_we=1, mem_d=wdata -> RESP.
- RMW_RD: mem_we=0. Capture mem_q into a merge register. Replace the addressed lane with wdata[7:0] (SB) or wdata[15:0] (SH). Go to RMW_WR.
- RMW_WR: mem_we=1, mem_d=merged word -> RESP.
- RESP: rsp_valid=1, rsp_err=0 -> IDLE.
- ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0. No memory access. -> IDLE.
- No response backpressure: the core must take rsp_valid in the cycle it is asserted.
- mem_we = (state is STORE or RMW_WR) AND reset_n. This gating guarantees no RAM write at any edge where reset_n=0.

## Timing
- Reset values (clock edge with reset_n=0):
  - state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_addr=0, mem_d=0, mem_we=0.
  - req_ready=1 from the first cycle after reset releases; req_ready=0 during reset.
- mem_addr and mem_d are registered and stable for the whole access state. mem_addr holds its last value in IDLE/RESP.
- Let acceptance be cycle 0. Then:
  - Loads and SW: access in cycle 1, rsp_valid in cycle 2.
  - SB/SH: read in cycle 1, write in cycle 2, rsp_valid in cycle 3.
  - Errors: rsp_valid in cycle 1.
- The next request can be accepted in the cycle after RESP/ERR, so back-to-back throughput is 3 or 4 cycles per access. req_ready is 0 in every non-IDLE state.
- rsp_rdata holds its value after a load until the next response. rsp_err is 0 whenever rsp_valid is 0.
- Reset mid-operation: the in-flight access is aborted, no response is issued, and no partial write occurs. If the read already happened, the RAM is unchanged.

## Test plan
- SW 0xDEADBEEF @0x0010, then LW @0x0010 -> rsp_rdata=0xDEADBEEF, rsp_err=0. SW response in cycle 2; mem_we high exactly one cycle.
- With word 0x11223344 @0x0020: SB 0xAA @0x0022, then LW @0x0020 -> 0x11AA3344. Read-then-write sequence observed, SB rsp_valid in cycle 3.
- With word 0x8000807F @0x0030:
  - LB @0x0031 -> 0xFFFFFF80; LBU @0x0031 -> 0x00000080.
  - LH @0x0032 -> 0xFFFF8000; LHU @0x0030 -> 0x0000807F.
- LH @0x0041, LW @0x0042, and load with funct3=011 -> each gives rsp_err=1, rsp_rdata=0 in cycle 1, and mem_we never asserted.
- SH 0x5555 @0x0050 (word 0x0), with reset_n driven low during RMW_WR:
  - no write occurs; LW @0x0050 after reset returns 0x0.
  - all outputs hold their reset values and req_ready=1 the first cycle after release.
- With req_valid held high continuously for LW/SW/SB, each request is accepted only in IDLE and req_ready stays 0 during every access. Accesses at 0x1_0010 with MEM_DEPTH=16 alias to 0x0010.
